// File: rtl/game_ctrl.sv
// game_ctrl: conditions the WASD/Esc/Enter keys, runs the MENU/PLAY/PAUSE mode
// machine and moves the player sprite once per frame inside a clamped field.
module game_ctrl #(
    parameter int FIELD_W   = 640,
    parameter int FIELD_H   = 480,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int SPRITE    = 16,
    parameter int STEP      = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_w,
    input  logic             key_a,
    input  logic             key_s,
    input  logic             key_d,
    input  logic             key_esc,
    input  logic             key_enter,
    input  logic             frame_tick,
    output logic [1:0]       state,
    output logic [XW-1:0]    player_x,
    output logic [YW-1:0]    player_y,
    output logic             moved,
    output logic [CNT_W-1:0] play_frames
);

    localparam logic [1:0] ST_MENU  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int K_W   = 0;
    localparam int K_A   = 1;
    localparam int K_S   = 2;
    localparam int K_D   = 3;
    localparam int K_ESC = 4;
    localparam int K_ENT = 5;

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    localparam logic [XW-1:0] X_CTR = XW'((FIELD_W - SPRITE) / 2);
    localparam logic [YW-1:0] Y_CTR = YW'((FIELD_H - SPRITE) / 2);
    localparam logic signed [XW+1:0] X_MAX  = (XW+2)'(FIELD_W - SPRITE);
    localparam logic signed [YW+1:0] Y_MAX  = (YW+2)'(FIELD_H - SPRITE);
    localparam logic signed [XW+1:0] X_STEP = (XW+2)'(STEP);
    localparam logic signed [YW+1:0] Y_STEP = (YW+2)'(STEP);

    function automatic logic [XW-1:0] clamp_x(input logic signed [XW+1:0] v);
        if (v[XW+1])
            return '0;
        else if (v > X_MAX)
            return X_MAX[XW-1:0];
        else
            return v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic signed [YW+1:0] v);
        if (v[YW+1])
            return '0;
        else if (v > Y_MAX)
            return Y_MAX[YW-1:0];
        else
            return v[YW-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [5:0]     raw;
    logic [5:0]     sync_p0;
    logic [5:0]     sync_p1;
    logic [5:0]     db;
    logic [1:0]     ctl_dly;
    logic [DBW-1:0] db_cnt [6];
    logic           rise_esc;
    logic           rise_ent;

    assign raw = {key_enter, key_esc, key_d, key_s, key_a, key_w};

    // Stage p0/p1: two-flop synchroniser, then per-key debounce on the p1 level
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db      <= '0;
            ctl_dly <= '0;
            for (int k = 0; k < 6; k++)
                db_cnt[k] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            ctl_dly <= db[K_ENT:K_ESC];
            for (int k = 0; k < 6; k++) begin
                if (sync_p1[k] == db[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db[k]     <= ~db[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + DBW'(1);
                end
            end
        end
    end

    assign rise_esc = db[K_ESC] & ~ctl_dly[0];
    assign rise_ent = db[K_ENT] & ~ctl_dly[1];

    logic signed [XW+1:0] x_ext;
    logic signed [YW+1:0] y_ext;
    logic signed [XW+1:0] nx_raw;
    logic signed [YW+1:0] ny_raw;
    logic [XW-1:0]        nx;
    logic [YW-1:0]        ny;

    // Opposite keys held together cancel, so only a lone key moves an axis
    always_comb begin
        x_ext  = $signed({2'b00, player_x});
        y_ext  = $signed({2'b00, player_y});
        nx_raw = x_ext;
        ny_raw = y_ext;
        if (db[K_D] && !db[K_A])
            nx_raw = x_ext + X_STEP;
        else if (db[K_A] && !db[K_D])
            nx_raw = x_ext - X_STEP;
        if (db[K_S] && !db[K_W])
            ny_raw = y_ext + Y_STEP;
        else if (db[K_W] && !db[K_S])
            ny_raw = y_ext - Y_STEP;
    end

    assign nx = clamp_x(nx_raw);
    assign ny = clamp_y(ny_raw);

    // Stage p2: mode machine and per-frame position/counter update
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_MENU;
            player_x    <= X_CTR;
            player_y    <= Y_CTR;
            moved       <= 1'b0;
            play_frames <= '0;
        end else begin
            moved <= 1'b0;
            case (state)
                ST_MENU: begin
                    if (rise_ent) begin
                        state       <= ST_PLAY;
                        player_x    <= X_CTR;
                        player_y    <= Y_CTR;
                        play_frames <= '0;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        player_x    <= nx;
                        player_y    <= ny;
                        moved       <= (nx != player_x) || (ny != player_y);
                        play_frames <= sat_inc(play_frames);
                    end
                    if (rise_esc)
                        state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (rise_esc)
                        state <= ST_MENU;
                    else if (rise_ent)
                        state <= ST_PLAY;
                end
                default: state <= ST_MENU;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed test-plan scenarios plus randomized key/tick traffic,
// checked every cycle against a behavioural model of the game controller.
module tb_game_ctrl;

    localparam int FW = 64;
    localparam int FH = 48;
    localparam int SP = 8;
    localparam int STP = 4;
    localparam int DB = 4;
    localparam int CW = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0;
    logic key_esc = 1'b0, key_enter = 1'b0;
    logic frame_tick = 1'b0;
    logic [1:0]    state;
    logic [XW-1:0] player_x;
    logic [YW-1:0] player_y;
    logic          moved;
    logic [CW-1:0] play_frames;

    int checks = 0;
    int errors = 0;

    game_ctrl #(
        .FIELD_W(FW), .FIELD_H(FH), .XW(XW), .YW(YW), .SPRITE(SP),
        .STEP(STP), .DB_CYCLES(DB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .key_w(key_w), .key_a(key_a), .key_s(key_s), .key_d(key_d),
        .key_esc(key_esc), .key_enter(key_enter),
        .frame_tick(frame_tick),
        .state(state), .player_x(player_x), .player_y(player_y),
        .moved(moved), .play_frames(play_frames)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Behavioural model: a key level is accepted once the synchronised level has
    // disagreed with the accepted level for DB consecutive edges.
    int          m_state, m_x, m_y, m_frames;
    bit          m_moved;
    bit          m_valid = 1'b0;
    bit [5:0]    m_s1, m_s2, m_db, m_dbq;
    int unsigned m_win [6];
    bit [5:0]    m_raw;
    bit          m_re, m_rn;
    int          m_nx, m_ny;
    int unsigned m_mask;

    always @(posedge clk) begin
        m_raw  = {key_enter, key_esc, key_d, key_s, key_a, key_w};
        m_mask = (32'd1 << DB) - 1;
        if (!rst) begin
            m_state  = 0;
            m_x      = (FW - SP) / 2;
            m_y      = (FH - SP) / 2;
            m_moved  = 0;
            m_frames = 0;
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0;
            for (int k = 0; k < 6; k++) m_win[k] = 0;
            m_valid = 1'b1;
        end else begin
            m_re = m_db[4] && !m_dbq[4];
            m_rn = m_db[5] && !m_dbq[5];
            m_moved = 0;
            if (m_state == 0) begin
                if (m_rn) begin
                    m_state = 1; m_x = (FW - SP) / 2; m_y = (FH - SP) / 2; m_frames = 0;
                end
            end else if (m_state == 1) begin
                if (frame_tick) begin
                    m_nx = clampi(m_x + STP * (int'(m_db[3]) - int'(m_db[1])), 0, FW - SP);
                    m_ny = clampi(m_y + STP * (int'(m_db[2]) - int'(m_db[0])), 0, FH - SP);
                    m_moved = (m_nx != m_x) || (m_ny != m_y);
                    m_x = m_nx;
                    m_y = m_ny;
                    if (m_frames < (2 ** CW) - 1) m_frames++;
                end
                if (m_re) m_state = 2;
            end else begin
                if (m_re) m_state = 0;
                else if (m_rn) m_state = 1;
            end
            m_dbq = m_db;
            for (int k = 0; k < 6; k++) begin
                m_win[k] = (m_win[k] << 1) | int'(m_s2[k]);
                if (m_db[k] ? ((m_win[k] & m_mask) == 0) : ((m_win[k] & m_mask) == m_mask))
                    m_db[k] = !m_db[k];
            end
            m_s2 = m_s1;
            m_s1 = m_raw;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state", state, m_state);
            check("model_x", player_x, m_x);
            check("model_y", player_y, m_y);
            check("model_moved", moved, m_moved);
            check("model_frames", play_frames, m_frames);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_w = v;
            1: key_a = v;
            2: key_s = v;
            3: key_d = v;
            4: key_esc = v;
            default: key_enter = v;
        endcase
    endtask

    task automatic event_key(input int k);
        set_key(k, 1'b1);
        step(8);
        set_key(k, 1'b0);
        step(8);
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    int exp_x3 [10] = '{32, 36, 40, 44, 48, 52, 56, 56, 56, 56};
    bit exp_m3 [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit [5:0] kv;

    initial begin
        step(2);
        rst = 1'b1;
        step(2);
        check("rst_state", state, 0);
        check("rst_x", player_x, 28);
        check("rst_y", player_y, 20);
        check("rst_moved", moved, 0);
        check("rst_frames", play_frames, 0);

        // short enter glitch is rejected
        key_enter = 1'b1; step(3); key_enter = 1'b0; step(10);
        check("glitch_state", state, 0);

        // enter held 20 cycles: PLAY exactly 7 edges after the raw rise
        key_enter = 1'b1;
        step(6);
        check("enter_e6", state, 0);
        step(1);
        check("enter_e7", state, 1);
        step(13);
        key_enter = 1'b0;
        step(8);

        // hold d: clamp at 56
        key_d = 1'b1; step(8);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            check("right_x", player_x, exp_x3[i]);
            check("right_moved", moved, exp_m3[i]);
            step(1);
        end
        key_d = 1'b0; key_a = 1'b1; step(8);
        repeat (20) begin do_tick(); step(1); end
        check("left_x", player_x, 0);
        key_a = 1'b0; step(8);

        // fresh PLAY, opposing keys and frame counter saturation
        event_key(4); check("pause1", state, 2);
        event_key(4); check("menu1", state, 0);
        event_key(5); check("play1", state, 1);
        check("play1_x", player_x, 28);
        check("play1_frames", play_frames, 0);
        key_w = 1'b1; key_s = 1'b1; step(8);
        repeat (3) begin
            do_tick();
            check("ws_y", player_y, 20);
            check("ws_moved", moved, 0);
            step(1);
        end
        check("ws_frames3", play_frames, 3);
        repeat (20) begin do_tick(); step(1); end
        check("frames_sat", play_frames, 15);
        key_w = 1'b0; key_s = 1'b0; step(8);

        // mode transitions keep or recentre the position
        key_d = 1'b1; step(8);
        repeat (3) begin do_tick(); step(1); end
        check("x40", player_x, 40);
        event_key(4); check("pause2", state, 2);
        do_tick();
        check("pause_x", player_x, 40);
        check("pause_moved", moved, 0);
        key_d = 1'b0; step(8);
        event_key(5); check("resume", state, 1);
        check("resume_x", player_x, 40);
        event_key(4); event_key(4); event_key(5);
        check("replay_state", state, 1);
        check("replay_x", player_x, 28);
        check("replay_frames", play_frames, 0);

        // esc rise coinciding with frame_tick
        key_d = 1'b1; step(8);
        key_esc = 1'b1; step(6);
        frame_tick = 1'b1; step(1); frame_tick = 1'b0;
        check("coinc_state", state, 2);
        check("coinc_x", player_x, 32);
        check("coinc_moved", moved, 1);
        key_esc = 1'b0; key_d = 1'b0; step(8);

        // reset during a debounce count, key held across it
        key_enter = 1'b1; step(3);
        rst = 1'b0; step(1); rst = 1'b1;
        check("mrst_state", state, 0);
        check("mrst_x", player_x, 28);
        check("mrst_y", player_y, 20);
        check("mrst_frames", play_frames, 0);
        step(6);
        check("mrst_e6", state, 0);
        step(1);
        check("mrst_e7", state, 1);
        key_enter = 1'b0; step(8);

        // randomized traffic
        kv = '0;
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < 6; k++)
                if ($urandom_range(5) == 0) kv[k] = ~kv[k];
            {key_enter, key_esc, key_d, key_s, key_a, key_w} = kv;
            frame_tick = ($urandom_range(3) == 0);
            rst = ($urandom_range(399) != 0);
            step(1);
        end
        {key_enter, key_esc, key_d, key_s, key_a, key_w} = '0;
        frame_tick = 1'b0;
        rst = 1'b1;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
